ac_exec_unit: RTL and testbench

//  Parametrised, registered successor of the basic-computer ALU. Owns the AC and E registers.

---
 rtl/ac_exec_pkg.sv | 8 +
 rtl/ac_exec_unit_if.sv | 15 +
 rtl/ac_exec_unit_mult.sv | 39 +++
 rtl/ac_exec_unit.sv | 81 ++++++++
 tb/tb_ac_exec_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ac_exec_pkg.sv
// ac_exec_pkg: opcode and FSM state types shared by the accumulator execution unit
package ac_exec_pkg;
  typedef enum logic [3:0] {
    NOP = 4'd0, AND = 4'd1, ADD = 4'd2, SUB = 4'd3, LDA = 4'd4, CLA = 4'd5, CLE = 4'd6,
    CMA = 4'd7, CME = 4'd8, CIR = 4'd9, CIL = 4'd10, INC = 4'd11, MUL = 4'd12
  } op_t;
  typedef enum logic {IDLE, MUL_RUN} state_t;
endpackage

// File: rtl/ac_exec_unit_if.sv
// ac_exec_unit_if: op issue handshake (op_valid/op_ready/op/dr) plus AC/E, done and skip-flag outputs
interface ac_exec_unit_if import ac_exec_pkg::*; #(parameter int WIDTH = 16);
  logic op_valid;
  logic op_ready;
  op_t op;
  logic [WIDTH-1:0] dr;
  logic [WIDTH-1:0] ac_out;
  logic e_out;
  logic done;
  logic ac_zero;
  logic ac_neg;
  logic e_zero;
  modport master (output op_valid, op, dr, input op_ready, ac_out, e_out, done, ac_zero, ac_neg, e_zero);
  modport slave (input op_valid, op, dr, output op_ready, ac_out, e_out, done, ac_zero, ac_neg, e_zero);
endinterface

// File: rtl/ac_exec_unit_mult.sv
// shift_add_mult: unsigned shift-add multiplier, one step per clock; ports clk, rst, start, mcand, mplier -> done (last step this edge), product (includes the current step)
module shift_add_mult #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [WIDTH-1:0] mcand,
  input logic [WIDTH-1:0] mplier,
  output logic done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] mc, prod;
  logic [WIDTH-1:0] mp;
  logic [CW-1:0] cnt;
  logic busy;
  assign product = prod + (mp[0] ? mc : '0);
  assign done = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      mc <= '0;
      mp <= '0;
      prod <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      mc <= {{WIDTH{1'b0}}, mcand};
      mp <= mplier;
      prod <= '0;
    end else if (busy) begin
      prod <= product;
      mc <= mc << 1;
      mp <= mp >> 1;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/ac_exec_unit.sv
// ac_exec_unit: registered AC/E accumulator unit; ports clk, rst, bus (op_valid/op_ready/op/dr in, ac_out/e_out/done/ac_zero/ac_neg/e_zero out)
module ac_exec_unit import ac_exec_pkg::*; #(
  parameter int WIDTH = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  ac_exec_unit_if.slave bus
);
  logic [WIDTH-1:0] ac, ac_n;
  logic e, e_n, ready, done, accept, mul_start, mul_done;
  logic [WIDTH:0] add_r, sub_r, inc_r;
  logic [2*WIDTH-1:0] product;
  state_t state;
  assign accept = bus.op_valid && ready;
  assign mul_start = accept && bus.op == MUL && MUL_EN;
  assign bus.op_ready = ready;
  assign bus.done = done;
  assign bus.ac_out = ac;
  assign bus.e_out = e;
  assign bus.ac_zero = ac == '0;
  assign bus.ac_neg = ac[WIDTH-1];
  assign bus.e_zero = !e;
  always_comb begin
    add_r = {1'b0, ac} + {1'b0, bus.dr};
    sub_r = {1'b0, ac} + {1'b0, ~bus.dr} + 1'b1;
    inc_r = {1'b0, ac} + 1'b1;
    ac_n = ac;
    e_n = e;
    case (bus.op)
      AND: ac_n = ac & bus.dr;
      ADD: {e_n, ac_n} = add_r;
      SUB: {e_n, ac_n} = sub_r;
      LDA: ac_n = bus.dr;
      CLA: ac_n = '0;
      CLE: e_n = 1'b0;
      CMA: ac_n = ~ac;
      CME: e_n = !e;
      CIR: {ac_n, e_n} = {e, ac};
      CIL: {e_n, ac_n} = {ac, e};
      INC: {e_n, ac_n} = inc_r;
      default: ;
    endcase
  end
  if (MUL_EN) begin : g_mul
    shift_add_mult #(.WIDTH(WIDTH)) u_mult (
      .clk(clk), .rst(rst), .start(mul_start), .mcand(ac), .mplier(bus.dr),
      .done(mul_done), .product(product)
    );
  end else begin : g_no_mul
    assign mul_done = 1'b0;
    assign product = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ac <= '0;
      e <= 1'b0;
      state <= IDLE;
      ready <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (mul_start) begin
          state <= MUL_RUN;
          ready <= 1'b0;
        end else if (accept) begin
          ac <= ac_n;
          e <= e_n;
          done <= 1'b1;
        end
      end else if (mul_done) begin
        ac <= product[WIDTH-1:0];
        e <= |product[2*WIDTH-1:WIDTH];
        state <= IDLE;
        ready <= 1'b1;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ac_exec_unit.sv
// tb_ac_exec_unit: scoreboard bench for ac_exec_unit (MUL_EN=1 main DUT, MUL_EN=0 secondary DUT)
module tb_ac_exec_unit;
  import ac_exec_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [15:0] m_ac = '0;
  logic m_e = 1'b0;
  logic [16:0] sbq[$];
  ac_exec_unit_if #(.WIDTH(16)) bus();
  ac_exec_unit_if #(.WIDTH(16)) bus2();
  ac_exec_unit #(.WIDTH(16), .MUL_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  ac_exec_unit #(.WIDTH(16), .MUL_EN(1'b0)) dut_nomul (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  function automatic logic [16:0] model(input op_t o, input logic [15:0] a, input logic e, input logic [15:0] d);
    logic [31:0] p;
    p = 32'(a) * 32'(d);
    case (o)
      AND: return {e, a & d};
      ADD: return {1'b0, a} + {1'b0, d};
      SUB: return {1'b0, a} + {1'b0, ~d} + 17'd1;
      LDA: return {e, d};
      CLA: return {e, 16'h0000};
      CLE: return {1'b0, a};
      CMA: return {e, ~a};
      CME: return {~e, a};
      CIR: return {a[0], e, a[15:1]};
      CIL: return {a, e};
      INC: return {1'b0, a} + 17'd1;
      MUL: return {|p[31:16], p[15:0]};
      default: return {e, a};
    endcase
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done ac=%h e=%b required no done", bus.ac_out, bus.e_out);
      end else begin
        logic [16:0] x;
        x = sbq.pop_front();
        if ({bus.e_out, bus.ac_out} !== x) begin
          failures++;
          $display("FAIL sb_result e,ac=%b,%h required %b,%h", bus.e_out, bus.ac_out, x[16], x[15:0]);
        end
      end
    end
  end
  task automatic issue(input op_t o, input logic [15:0] d);
    logic [16:0] r;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op = o;
    bus.dr = d;
    r = model(o, m_ac, m_e, d);
    {m_e, m_ac} = r;
    sbq.push_back(r);
    @(posedge clk);
  endtask
  task automatic idle();
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.op_valid = 1'b1;
    bus.op = LDA;
    bus.dr = 16'hFFFF;
    bus2.op_valid = 1'b0;
    bus2.op = NOP;
    bus2.dr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ac_out !== 16'h0000) begin failures++; $display("FAIL reset_ac got %h required 0000", bus.ac_out); end
    checks++; if (bus.e_out !== 1'b0) begin failures++; $display("FAIL reset_e got %b required 0", bus.e_out); end
    checks++; if (bus.op_ready !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL reset_hs ready=%b done=%b required 1,0", bus.op_ready, bus.done); end
    checks++; if (bus.ac_zero !== 1'b1) begin failures++; $display("FAIL reset_ac_zero got %b required 1", bus.ac_zero); end
    bus.op_valid = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_add_carry();
    int d0;
    d0 = done_cnt;
    issue(LDA, 16'hFFFF);
    issue(ADD, 16'h0001);
    idle();
    checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL add_done_count got %0d required 2", done_cnt - d0); end
    checks++; if (bus.ac_out !== 16'h0000 || bus.e_out !== 1'b1) begin failures++; $display("FAIL add_result ac=%h e=%b required 0000,1", bus.ac_out, bus.e_out); end
    checks++; if (bus.ac_zero !== 1'b1) begin failures++; $display("FAIL add_ac_zero got %b required 1", bus.ac_zero); end
  endtask
  task automatic test_sub_inc();
    issue(LDA, 16'h0005);
    issue(SUB, 16'h0007);
    idle();
    checks++; if (bus.ac_out !== 16'hFFFE || bus.e_out !== 1'b0) begin failures++; $display("FAIL sub_result ac=%h e=%b required fffe,0", bus.ac_out, bus.e_out); end
    checks++; if (bus.ac_neg !== 1'b1) begin failures++; $display("FAIL sub_ac_neg got %b required 1", bus.ac_neg); end
    issue(INC, 16'h0000);
    issue(INC, 16'h0000);
    issue(op_t'(4'd14), 16'h1234);
    issue(AND, 16'h00F0);
    idle();
    checks++; if (bus.ac_out !== 16'h0000 || bus.e_out !== 1'b1) begin failures++; $display("FAIL inc_result ac=%h e=%b required 0000,1", bus.ac_out, bus.e_out); end
  endtask
  task automatic test_rotate();
    issue(LDA, 16'h8001);
    issue(CLE, 16'h0000);
    issue(CIL, 16'h0000);
    idle();
    checks++; if (bus.ac_out !== 16'h0002 || bus.e_out !== 1'b1) begin failures++; $display("FAIL cil_result ac=%h e=%b required 0002,1", bus.ac_out, bus.e_out); end
    issue(LDA, 16'h0001);
    issue(CIR, 16'h0000);
    idle();
    checks++; if (bus.ac_out !== 16'h8000 || bus.e_out !== 1'b1) begin failures++; $display("FAIL cir_result ac=%h e=%b required 8000,1", bus.ac_out, bus.e_out); end
    issue(CME, 16'h0000);
    issue(CMA, 16'h0000);
    issue(CLA, 16'h0000);
    issue(LDA, 16'h00FF);
    idle();
    checks++; if (bus.e_out !== 1'b0 || bus.e_zero !== 1'b1) begin failures++; $display("FAIL cme_result e=%b e_zero=%b required 0,1", bus.e_out, bus.e_zero); end
  endtask
  task automatic run_mul(input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_ac, input logic exp_e);
    int low, d0;
    bit seen;
    issue(LDA, a);
    issue(MUL, d);
    d0 = done_cnt;
    low = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.op_ready) begin
        seen = 1'b1;
        bus.op_valid = 1'b0;
        break;
      end
      low++;
      bus.op_valid = 1'b1;
      bus.op = LDA;
      bus.dr = 16'h5555;
      if (low == 8) begin
        checks++; if (bus.ac_out !== a) begin failures++; $display("FAIL mul_ac_hold got %h required %h", bus.ac_out, a); end
      end
    end
    checks++; if (!seen || low !== 16) begin failures++; $display("FAIL mul_ready_low cycles=%0d returned=%b required 16,1", low, seen); end
    @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL mul_done_count got %0d required 1", done_cnt - d0); end
    checks++; if (bus.ac_out !== exp_ac || bus.e_out !== exp_e) begin failures++; $display("FAIL mul_result ac=%h e=%b required %h,%b", bus.ac_out, bus.e_out, exp_ac, exp_e); end
  endtask
  task automatic test_mul();
    run_mul(16'h0123, 16'h0010, 16'h1230, 1'b0);
    run_mul(16'h8000, 16'h0002, 16'h0000, 1'b1);
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
  endtask
  task automatic test_mul_reset();
    int d0;
    issue(LDA, 16'h0123);
    issue(MUL, 16'h0010);
    d0 = done_cnt;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    m_ac = '0;
    m_e = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.op_ready !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL mulrst_hs ready=%b done=%b required 1,0", bus.op_ready, bus.done); end
    checks++; if (bus.ac_out !== 16'h0000 || bus.e_out !== 1'b0) begin failures++; $display("FAIL mulrst_state ac=%h e=%b required 0000,0", bus.ac_out, bus.e_out); end
    repeat (20) @(negedge clk);
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL mulrst_no_done dones=%0d required %0d", done_cnt, d0); end
  endtask
  task automatic test_nomul();
    @(negedge clk);
    bus2.op_valid = 1'b1;
    bus2.op = LDA;
    bus2.dr = 16'h0003;
    @(negedge clk);
    bus2.op = MUL;
    bus2.dr = 16'h0005;
    @(negedge clk);
    bus2.op_valid = 1'b0;
    checks++; if (bus2.done !== 1'b1 || bus2.op_ready !== 1'b1) begin failures++; $display("FAIL nomul_hs done=%b ready=%b required 1,1", bus2.done, bus2.op_ready); end
    checks++; if (bus2.ac_out !== 16'h0003 || bus2.e_out !== 1'b0) begin failures++; $display("FAIL nomul_result ac=%h e=%b required 0003,0", bus2.ac_out, bus2.e_out); end
  endtask
  initial begin
    bus.op_valid = 1'b0;
    bus.op = NOP;
    bus.dr = '0;
    test_reset();
    test_add_carry();
    test_sub_inc();
    test_rotate();
    test_mul();
    test_mul_reset();
    test_nomul();
    checks++; if (sbq.size() !== 0) begin failures++; $display("FAIL sb_drain pending=%0d required 0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
